// File: rtl/xbus_mcast_fifo_if.sv
// Handshake bundle between the GLB read port, the multicast FIFO and one PE row.
// slave  : the multicast FIFO's view (accepts tagged input, drives the per-PE side).
// master : the environment's view (offers tagged input, supplies per-PE ready).
interface xbus_mcast_fifo_if #(
   parameter int PE_NUMS   = 14,
   parameter int ID_LEN    = 5,
   parameter int VALUE_LEN = 32
);
   logic                           in_valid;
   logic                           in_ready;
   logic [ID_LEN+VALUE_LEN-1:0]    in_tag_value;
   logic [PE_NUMS-1:0]             pe_ready;
   logic [PE_NUMS-1:0]             pe_valid;
   logic [PE_NUMS*VALUE_LEN-1:0]   pe_value;

   modport master (
      output in_valid, in_tag_value, pe_ready,
      input  in_ready, pe_valid, pe_value
   );

   modport slave (
      input  in_valid, in_tag_value, pe_ready,
      output in_ready, pe_valid, pe_value
   );
endinterface

// File: rtl/xbus_mcast_fifo.sv
// Horizontal multicast bus for one PE row: an input FIFO of {tag, value} words,
// a delivery register that presents the head value to every PE whose scan-loaded
// ID matches the tag, a pending mask tracking which targets still owe a handshake,
// and a saturating counter of tags that matched nobody.
// Optional feature: define XBUS_BCAST_EN to make the all-ones tag a broadcast
// that matches every PE (the all-ones ID is then reserved).
module xbus_mcast_fifo #(
   parameter int PE_NUMS    = 14,
   parameter int ID_LEN     = 5,
   parameter int VALUE_LEN  = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_LEN    = 16
) (
   input  logic                clk,
   input  logic                rst,
   xbus_mcast_fifo_if.slave    bus,
   input  logic                set_id,
   input  logic [ID_LEN-1:0]   id_scan_in,
   output logic [ID_LEN-1:0]   id_scan_out,
   output logic                busy,
   output logic [CNT_LEN-1:0]  drop_cnt
);
   localparam int              PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT  = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [0:0]      ST_IDLE    = 1'b0;
   localparam logic [0:0]      ST_DELIVER = 1'b1;

   logic [ID_LEN+VALUE_LEN-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]              count_q, count_d;
   logic [0:0]                  state_q, state_d;
   logic [PE_NUMS-1:0]          pending_q, pending_d;
   logic [VALUE_LEN-1:0]        value_q, value_d;
   logic [CNT_LEN-1:0]          drop_q, drop_d;
   logic [ID_LEN-1:0]           id_q [PE_NUMS];
   logic [ID_LEN-1:0]           id_d [PE_NUMS];

   logic                        empty, full, push, pop, scan_en, deliver_done;
   logic [ID_LEN-1:0]           head_tag;
   logic [VALUE_LEN-1:0]        head_value;
   logic [PE_NUMS-1:0]          head_mask;

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_CNT);
   assign bus.in_ready = !full && !set_id;
   assign push         = bus.in_valid && bus.in_ready;
   assign {head_tag, head_value} = mem_q[rd_ptr_q];
   // Every still-pending target is accepting this cycle, so the word retires at this edge.
   assign deliver_done = ((pending_q & ~bus.pe_ready) == '0);
   // IDs only move when nothing is queued or in flight, so a rescan never races a delivery.
   assign scan_en      = set_id && (state_q == ST_IDLE) && empty;

   assign bus.pe_valid = pending_q;
   assign busy         = !empty || (state_q == ST_DELIVER);
   assign drop_cnt     = drop_q;
   assign id_scan_out  = id_q[PE_NUMS-1];

   generate
      for (genvar gi = 0; gi < PE_NUMS; gi++) begin : g_pe
`ifdef XBUS_BCAST_EN
         assign head_mask[gi] = (id_q[gi] == head_tag) || (head_tag == {ID_LEN{1'b1}});
`else
         assign head_mask[gi] = (id_q[gi] == head_tag);
`endif
         assign bus.pe_value[gi*VALUE_LEN +: VALUE_LEN] = value_q;

         if (gi == 0) begin : g_first
            assign id_d[gi] = scan_en ? id_scan_in : id_q[gi];
         end else begin : g_chain
            assign id_d[gi] = scan_en ? id_q[gi-1] : id_q[gi];
         end

         // Scan-chain ID register for this PE
         always_ff @(posedge clk) begin
            if (rst) id_q[gi] <= '0;
            else     id_q[gi] <= id_d[gi];
         end
      end
   endgenerate

   // Delivery FSM: retire the current word, then pop and classify the next head in the same edge
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      value_d   = value_q;
      drop_d    = drop_q;
      pop       = 1'b0;
      if (state_q == ST_DELIVER)
         pending_d = pending_q & ~bus.pe_ready;
      if ((state_q == ST_IDLE) || deliver_done) begin
         state_d = ST_IDLE;
         if (!empty) begin
            pop = 1'b1;
            if (head_mask != '0) begin
               state_d   = ST_DELIVER;
               pending_d = head_mask;
               value_d   = head_value;
            end else begin
               pending_d = '0;
               if (drop_q != '1)
                  drop_d = drop_q + 1'b1;
            end
         end
      end
   end

   // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-2 depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_tag_value;
   end

   // Control and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         pending_q <= '0;
         value_q   <= '0;
         drop_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         pending_q <= pending_d;
         value_q   <= value_d;
         drop_q    <= drop_d;
      end
   end
endmodule

// File: tb/tb_xbus_mcast_fifo.sv
// Directed bench for xbus_mcast_fifo: reset state, ID scan, single-target and
// all-target delivery, FIFO fill with head-of-line stall, unmatched-tag drop
// (broadcast when XBUS_BCAST_EN is defined) and reset in the middle of delivery.
module tb_xbus_mcast_fifo;
   localparam int PE_NUMS = 14;
   localparam int ID_LEN = 5;
   localparam int VALUE_LEN = 32;
   localparam logic [PE_NUMS-1:0] ALL_PE = {PE_NUMS{1'b1}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_id = 1'b0;
   logic [ID_LEN-1:0] id_scan_in = '0;
   logic [ID_LEN-1:0] id_scan_out;
   logic busy;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   xbus_mcast_fifo_if #(.PE_NUMS(PE_NUMS), .ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN)) xif ();

   xbus_mcast_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (xif),
      .set_id      (set_id),
      .id_scan_in  (id_scan_in),
      .id_scan_out (id_scan_out),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [ID_LEN-1:0] tag, input logic [VALUE_LEN-1:0] val);
      xif.in_valid = 1'b1;
      xif.in_tag_value = {tag, val};
      step();
      xif.in_valid = 1'b0;
   endtask

   task automatic shift_id(input logic [ID_LEN-1:0] v);
      set_id = 1'b1;
      id_scan_in = v;
      step();
   endtask

   function automatic logic [VALUE_LEN-1:0] pe_val(input int i);
      return xif.pe_value[i*VALUE_LEN +: VALUE_LEN];
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      xif.in_valid = 1'b0;
      xif.in_tag_value = '0;
      xif.pe_ready = ALL_PE;

      // Reset state
      step(); step();
      rst = 1'b0;
      chk("rst_pe_valid", 64'(xif.pe_valid), 64'h0);
      chk("rst_pe_value_any", 64'(|xif.pe_value), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
      chk("rst_in_ready", 64'(xif.in_ready), 64'h1);
      chk("rst_id_scan_out", 64'(id_scan_out), 64'h0);

      // Scan 0..13: id[i] = 13-i
      set_id = 1'b1;
      #1;
      chk("scan_in_ready_low", 64'(xif.in_ready), 64'h0);
      for (int i = 0; i < PE_NUMS; i++) shift_id(ID_LEN'(i));
      chk("scan_out_after_14", 64'(id_scan_out), 64'h0);
      set_id = 1'b0;
      #1;

      // Tag 5 lands on PE 8 only; two-cycle latency, one-cycle transfer
      push(5'd5, 32'hDEAD_0005);
      chk("t5_lat1_valid", 64'(xif.pe_valid), 64'h0);
      chk("t5_lat1_busy", 64'(busy), 64'h1);
      step();
      chk("t5_valid", 64'(xif.pe_valid), 64'h0100);
      chk("t5_value_pe8", 64'(pe_val(8)), 64'hDEAD_0005);
      step();
      chk("t5_done_valid", 64'(xif.pe_valid), 64'h0);
      chk("t5_done_busy", 64'(busy), 64'h0);

      // All IDs 3, tag 3 reaches every PE
      for (int i = 0; i < PE_NUMS; i++) shift_id(5'd3);
      chk("ids3_scan_out", 64'(id_scan_out), 64'h3);
      set_id = 1'b0;
      #1;
      push(5'd3, 32'hA5A5_A5A5);
      chk("all_lat1_valid", 64'(xif.pe_valid), 64'h0);
      step();
      chk("all_valid", 64'(xif.pe_valid), 64'(ALL_PE));
      chk("all_value_pe0", 64'(pe_val(0)), 64'hA5A5_A5A5);
      chk("all_value_pe13", 64'(pe_val(13)), 64'hA5A5_A5A5);
      step();
      chk("all_done_valid", 64'(xif.pe_valid), 64'h0);

      // IDs 0..13 again; PE5 holds id 8. Stall PE5 and fill the FIFO.
      for (int i = 0; i < PE_NUMS; i++) shift_id(ID_LEN'(i));
      set_id = 1'b0;
      xif.pe_ready = ALL_PE & ~(14'h0020);
      #1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) chk("fill_in_ready_before_last", 64'(xif.in_ready), 64'h1);
         push(5'd8, 32'h1111_1111 * (k + 1));
      end
      chk("fill_in_ready_full", 64'(xif.in_ready), 64'h0);
      chk("fill_valid_pe5", 64'(xif.pe_valid), 64'h0020);
      chk("fill_value_a", 64'(pe_val(5)), 64'h1111_1111);
      step();
      chk("stall_valid_pe5", 64'(xif.pe_valid), 64'h0020);
      chk("stall_in_ready", 64'(xif.in_ready), 64'h0);
      xif.pe_ready = ALL_PE;
      for (int k = 1; k < 5; k++) begin
         step();
         chk($sformatf("drain_valid_%0d", k), 64'(xif.pe_valid), 64'h0020);
         chk($sformatf("drain_value_%0d", k), 64'(pe_val(5)), 64'(32'h1111_1111 * (k + 1)));
      end
      chk("drain_in_ready", 64'(xif.in_ready), 64'h1);
      step();
      chk("drain_end_valid", 64'(xif.pe_valid), 64'h0);
      chk("drain_end_busy", 64'(busy), 64'h0);

      // Tag 31: no PE holds ID 31
`ifdef XBUS_BCAST_EN
      xif.pe_ready = ALL_PE & ~(14'h0001);
      push(5'd31, 32'h0BCA_0031);
      chk("bc_lat1_valid", 64'(xif.pe_valid), 64'h0);
      step();
      chk("bc_valid_all", 64'(xif.pe_valid), 64'(ALL_PE));
      step();
      chk("bc_valid_pe0_a", 64'(xif.pe_valid), 64'h0001);
      step();
      chk("bc_valid_pe0_b", 64'(xif.pe_valid), 64'h0001);
      xif.pe_ready = ALL_PE;
      step();
      chk("bc_done_valid", 64'(xif.pe_valid), 64'h0);
      chk("bc_done_busy", 64'(busy), 64'h0);
      chk("bc_drop_cnt", 64'(drop_cnt), 64'h0);
`else
      push(5'd31, 32'h0BCA_0031);
      chk("drop_lat1_valid", 64'(xif.pe_valid), 64'h0);
      chk("drop_lat1_busy", 64'(busy), 64'h1);
      step();
      chk("drop_valid", 64'(xif.pe_valid), 64'h0);
      chk("drop_cnt_1", 64'(drop_cnt), 64'h1);
      chk("drop_busy", 64'(busy), 64'h0);
`endif

      // Reset while delivering with three words queued
      xif.pe_ready = ALL_PE & ~(14'h0020);
      for (int k = 0; k < 4; k++) push(5'd8, 32'h2222_0000 + k);
      chk("mid_valid", 64'(xif.pe_valid), 64'h0020);
      chk("mid_busy", 64'(busy), 64'h1);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", 64'(xif.pe_valid), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_in_ready", 64'(xif.in_ready), 64'h1);
      chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'h0);
      rst = 1'b0;
      xif.pe_ready = ALL_PE;
      step();
      chk("post_rst_busy", 64'(busy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
